// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and helpers for the adder-sharing arbiter.
// Slot state encoding and an ID-width helper.
package adder_share_arbiter_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter (double-width masked scan).
// Ports: req, en, ptr in; one-hot gnt and binary gnt_idx out.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic [NREQ-1:0] rot;
    logic [IDW:0]    off;
    logic [IDW:0]    idx;
    logic            hit;

    always_comb begin
        // rotate so bit 0 is the requester at ptr
        rot = NREQ'({req, req} >> ptr);
        off = '0;
        hit = 1'b0;
        // descending scan: lowest set bit wins
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = (IDW+1)'(j);
                hit = 1'b1;
            end
        end
        idx = {1'b0, ptr} + off;
        if (idx >= (IDW+1)'(NREQ))
            idx = idx - (IDW+1)'(NREQ);
        gnt_idx = idx[IDW-1:0];
        gnt = '0;
        if (en && hit)
            gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// One WIDTH-bit adder time-shared among NREQ requesters.
// Ports: req_valid/req_a/req_b in, req_ready out; res_* valid/ready out.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 3,
    parameter int IDW   = clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    output logic [WIDTH-1:0]      res_sum,
    output logic                  res_carry,
    output logic [IDW-1:0]        res_id,
    input  logic                  res_ready
);

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_idx;
    logic [NREQ-1:0]  gnt;
    logic             can_accept;
    logic             arb_en;
    logic             granted;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH:0]   sum_w;
    logic [IDW-1:0]   ptr_next;

    // draining and refilling in the same cycle avoids a bubble
    assign can_accept = (state == ST_EMPTY)
                      | (res_ready & res_valid);
    // no acceptance while reset is asserted
    assign arb_en  = can_accept & rst_n;
    assign granted = |gnt;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .en      (arb_en),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign a_sel = req_a[gnt_idx*WIDTH +: WIDTH];
    assign b_sel = req_b[gnt_idx*WIDTH +: WIDTH];
    assign sum_w = {1'b0, a_sel} + {1'b0, b_sel};

    assign ptr_next = (gnt_idx == IDW'(NREQ - 1))
                    ? '0 : gnt_idx + IDW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_carry <= 1'b0;
            res_id    <= '0;
            rr_ptr    <= '0;
        end else if (granted) begin
            state     <= ST_FULL;
            res_valid <= 1'b1;
            res_sum   <= sum_w[WIDTH-1:0];
            res_carry <= sum_w[WIDTH];
            res_id    <= gnt_idx;
            rr_ptr    <= ptr_next;
        end else if (res_ready && res_valid) begin
            // drain only: payload holds its last value
            state     <= ST_EMPTY;
            res_valid <= 1'b0;
        end
    end

endmodule
